// File: rtl/vd_trellis_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vd_trellis_ctrl
// Purpose  : Sequencing controller for the hard-decision Viterbi decoder core.
//            Buffers received symbol pairs in a small FIFO, issues one trellis
//            step per cycle to the BMC/ACS array, counts steps per frame,
//            schedules path-metric normalization and starts traceback at the
//            end of each frame.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            in_valid/in_ready/in_pair - symbol pair input handshake
//            bmc_pair, acs_en, acs_init, acs_norm - BMC/ACS array controls
//            norm_req       - metric-overflow warning from the ACS array
//            tb_start, tb_busy - traceback handshake
//            step_cnt       - steps issued in the current frame
//            frame_done     - one-cycle pulse when a frame is fully decoded
//            busy           - controller is not idle
//            acs_tail       - tail (flush) step marker, optional
// Options  : define VD_TRELLIS_CTRL_TAIL_EN to append TAIL_LEN zero-input
//            flush steps to each frame and add the acs_tail output.
// Revision : 1.0 - initial release
// ============================================================================
module vd_trellis_ctrl #(
   parameter int FRAME_LEN  = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 10,
   parameter int ACS_LAT    = 2
`ifdef VD_TRELLIS_CTRL_TAIL_EN
   ,
   parameter int TAIL_LEN   = 6
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_pair,
   output logic [1:0]       bmc_pair,
   output logic             acs_en,
   output logic             acs_init,
   output logic             acs_norm,
   input  logic             norm_req,
   output logic             tb_start,
   input  logic             tb_busy,
   output logic [CNT_W-1:0] step_cnt,
   output logic             frame_done,
`ifdef VD_TRELLIS_CTRL_TAIL_EN
   output logic             acs_tail,
`endif
   output logic             busy
);

`ifdef VD_TRELLIS_CTRL_TAIL_EN
   localparam int TAIL_STEPS = TAIL_LEN;
`else
   localparam int TAIL_STEPS = 0;
`endif

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(FRAME_LEN + TAIL_STEPS);
   localparam int               AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0]      FULL_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [3:0]       DRAIN_END = 4'(ACS_LAT);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_INIT    = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_TB      = 3'd4;
   localparam logic [2:0] S_TB_WAIT = 3'd5;

   logic [2:0]       state;
   logic [1:0]       fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      fifo_cnt;
   logic [3:0]       drain_cnt;
   logic             norm_pending;

   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic [CNT_W-1:0] next_step;
   logic             norm_set;
   logic             norm_now;

   assign fifo_empty = (fifo_cnt == '0);
   assign in_ready   = (fifo_cnt != FULL_CNT);
   assign push       = in_valid & in_ready;
   assign pop        = (state == S_RUN) & ~fifo_empty;
   assign next_step  = step_cnt + CNT_W'(1);

   // A request seen while the norm step itself is on the outputs belongs to
   // that same overflow event, so it must not arm another normalization.
   assign norm_set = norm_req & ((state == S_RUN) | (state == S_DRAIN))
                   & ~(acs_en & acs_norm);
   // Bypass lets a request raised this cycle ride on the very next step.
   assign norm_now = norm_pending | norm_set;

   assign acs_init = (state == S_INIT);
   assign tb_start = (state == S_TB);
   assign busy     = (state != S_IDLE);

   // Storage needs no reset; occupancy and pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_pair;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         step_cnt     <= '0;
         drain_cnt    <= '0;
         norm_pending <= 1'b0;
         bmc_pair     <= 2'b00;
         acs_en       <= 1'b0;
         acs_norm     <= 1'b0;
         frame_done   <= 1'b0;
`ifdef VD_TRELLIS_CTRL_TAIL_EN
         acs_tail     <= 1'b0;
`endif
      end else begin
         acs_en     <= pop;
         acs_norm   <= pop & norm_now;
         frame_done <= 1'b0;
         if (pop) begin
            bmc_pair <= fifo_mem[rd_ptr];
         end
`ifdef VD_TRELLIS_CTRL_TAIL_EN
         // Steps beyond the data portion are flush steps.
         acs_tail <= pop & (step_cnt >= CNT_W'(FRAME_LEN));
`endif

         // Leftover pending at drain exit is dropped: traceback never needs it.
         if ((state == S_DRAIN) && (drain_cnt == DRAIN_END)) begin
            norm_pending <= 1'b0;
         end else if (pop & norm_now) begin
            norm_pending <= 1'b0;
         end else if (norm_set) begin
            norm_pending <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (!fifo_empty) state <= S_INIT;
            end
            S_INIT: begin
               step_cnt <= '0;
               state    <= S_RUN;
            end
            S_RUN: begin
               if (pop) begin
                  step_cnt <= next_step;
                  if (next_step == LAST_STEP) begin
                     drain_cnt <= '0;
                     state     <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // ACS_LAT+1 cycles lets the final step land in metric memory.
               if (drain_cnt == DRAIN_END) begin
                  state <= S_TB;
               end else begin
                  drain_cnt <= drain_cnt + 4'd1;
               end
            end
            S_TB: begin
               state <= S_TB_WAIT;
            end
            S_TB_WAIT: begin
               if (!tb_busy) begin
                  frame_done <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
